// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_SIZE = 10;
    localparam int DEF_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE
);
    logic                 req0;
    logic                 req1;
    logic                 wr0;
    logic                 wr1;
    logic [ADDR_SIZE-1:0] addr0;
    logic [ADDR_SIZE-1:0] addr1;
    logic [WORD_SIZE-1:0] wdata0;
    logic [WORD_SIZE-1:0] wdata1;
    logic                 ack0;
    logic                 ack1;
    logic [WORD_SIZE-1:0] rdata;
    logic                 busy;
    logic [ADDR_SIZE-1:0] ram_addr;
    logic [WORD_SIZE-1:0] ram_data_in;
    logic                 ram_wr;
    logic                 ram_cs;
    logic [WORD_SIZE-1:0] ram_data_out;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_data_out,
        output ack0, ack1, rdata, busy, ram_addr, ram_data_in, ram_wr, ram_cs
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_data_out,
        input  ack0, ack1, rdata, busy, ram_addr, ram_data_in, ram_wr, ram_cs
    );

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the two requesters.
// RAM_ARB_ROUND_ROBIN_EN: ties go to the requester not served last; otherwise requester 0 wins ties.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last_id,
    output logic    grant,
    output req_id_t win_id
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
    // Fixed priority has no use for the last-served id.
    logic unused_last_id;
    assign unused_last_id = last_id;
`endif

    always_comb begin
        grant  = req0 | req1;
        win_id = 1'b0;
        if (req0 && req1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            win_id = ~last_id;
`else
            win_id = 1'b0;
`endif
        end else if (req1) begin
            win_id = 1'b1;
        end
    end

    // Carried only so the mode is visible in elaboration reports.
    logic unused_mode;
    assign unused_mode = ROUND_ROBIN;

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter that drives a single-port RAM through a fixed SETUP/STROBE/HOLD access.
// RAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking; undefined gives fixed priority to requester 0.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    state_e               state_q, state_d;
    logic                 cur_wr_q, cur_wr_d;
    logic [ADDR_SIZE-1:0] cur_addr_q, cur_addr_d;
    logic [WORD_SIZE-1:0] cur_wdata_q, cur_wdata_d;
    req_id_t              cur_id_q, cur_id_d;

    logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [WORD_SIZE-1:0] ram_data_in_q, ram_data_in_d;
    logic                 ram_wr_q, ram_wr_d;
    logic                 ram_cs_q, ram_cs_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 busy_q, busy_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;

    logic                 grant;
    req_id_t              win_id;
    req_id_t              last_id;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    req_id_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && grant) begin
            last_d = win_id;
        end
    end

    // After reset requester 1 counts as served last, so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_id = last_q;
`else
    assign last_id = 1'b1;
`endif

    ram_arb_pick u_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .last_id (last_id),
        .grant   (grant),
        .win_id  (win_id)
    );

    // State and request-latch registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_wr_q    <= 1'b0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            cur_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_wr_q    <= cur_wr_d;
            cur_addr_q  <= cur_addr_d;
            cur_wdata_q <= cur_wdata_d;
            cur_id_q    <= cur_id_d;
        end
    end

    // Next state; the winner's request is latched only at the grant edge.
    always_comb begin
        state_d     = state_q;
        cur_wr_d    = cur_wr_q;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        cur_id_d    = cur_id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d     = SETUP;
                    cur_id_d    = win_id;
                    cur_wr_d    = win_id ? bus.wr1    : bus.wr0;
                    cur_addr_d  = win_id ? bus.addr1  : bus.addr0;
                    cur_wdata_d = win_id ? bus.wdata1 : bus.wdata0;
                end
            end
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_wr_d      = 1'b0;
        ram_cs_d      = 1'b0;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        busy_d        = (state_d != IDLE);
        rdata_d       = rdata_q;
        if (state_d != IDLE) begin
            ram_cs_d      = 1'b1;
            ram_addr_d    = cur_addr_d;
            ram_data_in_d = cur_wdata_d;
        end
        case (state_d)
            STROBE: ram_wr_d = cur_wr_d;
            HOLD: begin
                ack0_d = (cur_id_d == 1'b0);
                ack1_d = (cur_id_d == 1'b1);
                // Entering HOLD is the edge that closes STROBE: capture read data here.
                if (!cur_wr_d) begin
                    rdata_d = bus.ram_data_out;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_wr_q      <= 1'b0;
            ram_cs_q      <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            busy_q        <= 1'b0;
            rdata_q       <= '0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_wr_q      <= ram_wr_d;
            ram_cs_q      <= ram_cs_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            busy_q        <= busy_d;
            rdata_q       <= rdata_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data_in = ram_data_in_q;
    assign bus.ram_wr      = ram_wr_q;
    assign bus.ram_cs      = ram_cs_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.busy        = busy_q;
    assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected acks and write strobes, monitors check them.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.ADDR_SIZE(10), .WORD_SIZE(8)) bus ();

    ram_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem [0:1023];
    always @(posedge clk) if (bus.ram_wr && bus.ram_cs) mem[bus.ram_addr] <= bus.ram_data_in;
    assign bus.ram_data_out = mem[bus.ram_addr];

    typedef struct { bit id; bit rd; logic [7:0] rdata; int cyc; } ack_exp_t;
    typedef struct { logic [9:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ack monitor
    always @(negedge clk) begin
        ack_exp_t e;
        if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_unexpected: got ack0=%0b ack1=%0b expected none (cycle %0d)",
                         bus.ack0, bus.ack1, cyc);
            end else begin
                e = ack_q.pop_front();
                chk("ack0", bus.ack0, !e.id);
                chk("ack1", bus.ack1, e.id);
                chk("ack_cycle", cyc, e.cyc);
                chk("busy_hold", bus.busy, 1);
                if (e.rd) chk("rdata", bus.rdata, e.rdata);
            end
        end
    end

    // Write-strobe monitor: one pop per cycle ram_wr is high.
    always @(negedge clk) begin
        wr_exp_t w;
        if (bus.ram_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wr_unexpected: got ram_wr=1 addr=%0h expected ram_wr=0 (cycle %0d)",
                         bus.ram_addr, cyc);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", bus.ram_addr, w.addr);
                chk("wr_data", bus.ram_data_in, w.data);
                chk("wr_cycle", cyc, w.cyc);
                chk("wr_cs", bus.ram_cs, 1);
            end
        end
    end

    // Called at a negedge with the arbiter idle at the next edge unless lat says otherwise.
    task automatic do_req(input bit id, input bit wr, input logic [9:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int lat);
        bit seen = 1'b0;
        ack_q.push_back('{id, !wr, exp_rd, cyc + lat});
        if (wr) wr_q.push_back('{a, d, cyc + lat - 1});
        if (id) begin
            bus.wr1 = wr; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
        end else begin
            bus.wr0 = wr; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = id ? bus.ack1 : bus.ack0;
        end
        chk(id ? "ack1_seen" : "ack0_seen", seen, 1);
        if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus.req0 = 0; bus.req1 = 0; bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;

        apply_reset();
        chk("rst_ram_wr", bus.ram_wr, 0);
        chk("rst_ram_cs", bus.ram_cs, 0);
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_data_in", bus.ram_data_in, 0);
        chk("rst_rdata", bus.rdata, 0);

        do_req(0, 1, 10'h3FF, 8'hA5, 8'h00, 3);
        chk("idle_busy", bus.busy, 0);
        chk("idle_cs", bus.ram_cs, 0);
        chk("idle_addr_kept", bus.ram_addr, 10'h3FF);
        do_req(0, 0, 10'h3FF, 8'h00, 8'hA5, 3);
        do_req(1, 1, 10'h000, 8'h3C, 8'h00, 3);
        chk("rdata_kept_after_write", bus.rdata, 8'hA5);
        do_req(1, 0, 10'h000, 8'h00, 8'h3C, 3);

        // req0 rises during STROBE of req1's access.
        fork
            do_req(1, 0, 10'h000, 8'h00, 8'h3C, 3);
            begin
                repeat (2) @(negedge clk);
                do_req(0, 0, 10'h3FF, 8'h00, 8'hA5, 5);
            end
        join

        // Both requesters held high continuously.
        apply_reset();
        c = cyc;
        bus.wr0 = 0; bus.addr0 = 10'h3FF; bus.wr1 = 0; bus.addr1 = 10'h000;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        ack_q.push_back('{1'b0, 1'b1, 8'hA5, c + 3});
        ack_q.push_back('{1'b1, 1'b1, 8'h3C, c + 7});
        ack_q.push_back('{1'b0, 1'b1, 8'hA5, c + 11});
        ack_q.push_back('{1'b1, 1'b1, 8'h3C, c + 15});
`else
        ack_q.push_back('{1'b0, 1'b1, 8'hA5, c + 3});
        ack_q.push_back('{1'b0, 1'b1, 8'hA5, c + 7});
        ack_q.push_back('{1'b0, 1'b1, 8'hA5, c + 11});
        ack_q.push_back('{1'b0, 1'b1, 8'hA5, c + 15});
`endif
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        repeat (15) @(negedge clk);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("tie_acks_drained", ack_q.size(), 0);

        // Reset during STROBE of a write.
        c = cyc;
        wr_q.push_back('{10'h123, 8'h55, c + 2});
        bus.wr0 = 1; bus.addr0 = 10'h123; bus.wdata0 = 8'h55; bus.req0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("strobe_before_reset", bus.ram_wr, 1);
        rst_n = 1'b0; bus.req0 = 1'b0;
        @(negedge clk);
        chk("midrst_ram_wr", bus.ram_wr, 0);
        chk("midrst_ram_cs", bus.ram_cs, 0);
        chk("midrst_ack0", bus.ack0, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ram_addr", bus.ram_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1, 0, 10'h000, 8'h00, 8'h3C, 3);

        repeat (3) @(negedge clk);
        chk("ack_q_empty", ack_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and access sequencer for the shared single-port 1024x8 RAM (10-bit address, 8-bit word, combinational read, level-sensitive `wr`/`cs` write). It picks one requester, latches that request, and drives the RAM through a fixed four-cycle access. The access gives `wr` clean setup and hold around a one-cycle strobe. It then returns read data and a one-cycle acknowledge. It sits between two bus masters and the RAM instance and is the only driver of the RAM's `addr`, `data_in`, `wr` and `cs`.

## Interface
- `ADDR_SIZE`, 10, RAM address width
- `WORD_SIZE`, 8, RAM word width
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `req0`, `req1` in 1: request, held high until the matching `ack`
- `wr0`, `wr1` in 1: 1 = write, 0 = read; qualified by `req`
- `addr0`, `addr1` in ADDR_SIZE: request address
- `wdata0`, `wdata1` in WORD_SIZE: write data
- `ack0`, `ack1` out 1: one-cycle completion pulse
- `rdata` out WORD_SIZE: read data, valid while `ack0` or `ack1` is high for a read
- `busy` out 1: high in every state except IDLE
- `ram_addr` out ADDR_SIZE: to RAM `addr`
- `ram_data_in` out WORD_SIZE: to RAM `data_in`
- `ram_wr` out 1: to RAM `wr`
- `ram_cs` out 1: to RAM `cs`
- `ram_data_out` in WORD_SIZE: from RAM `data_out`

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. Transitions are IDLE to SETUP (any request), then SETUP to STROBE to HOLD to IDLE unconditionally.
- IDLE: if `req0` or `req1` is high, select a winner. Latch its `wr`, `addr` and `wdata` into `cur_wr`, `cur_addr` and `cur_wdata`. Record the winner id and go to SETUP. If there is no request, stay in IDLE.
- SETUP: `ram_cs`=1, `ram_addr`=`cur_addr`, `ram_data_in`=`cur_wdata`, `ram_wr`=0.
- STROBE: same as SETUP, plus `ram_wr`=`cur_wr`. For a read, `ram_data_out` is registered into `rdata` at the end of this cycle.
- HOLD: `ram_wr`=0 while address and data stay held and `ram_cs`=1. The winner's `ack` is 1.
- Back in IDLE: `ram_cs`=0. `ram_addr` and `ram_data_in` keep their last value.
- Arbitration (see Configuration): a lone request always wins. Only ties use the policy.
- A request still high in the IDLE cycle after its `ack` counts as a new request.
- Request inputs are ignored outside IDLE. Inputs are latched, so requesters only need them stable at the grant edge; the handshake still requires holding until `ack`.
- `rdata` keeps its value after a write access and until the next read completes.
- Reset (at any state, including mid-access): next edge gives IDLE. `ram_wr`, `ram_cs`, `ack0`, `ack1` and `busy` go to 0. `ram_addr`, `ram_data_in` and `rdata` go to 0. The round-robin pointer resets to "last served = 1". An interrupted write may or may not have landed, and the requester reissues it.

## Timing
- All outputs are registered. No combinational path runs from inputs to outputs.
- Request sampled in IDLE at edge T: SETUP in cycle T+1, STROBE in T+2, HOLD (`ack`) in T+3, IDLE in T+4.
- Request-to-ack latency is 3 cycles after the sampling edge. Peak throughput is one access per 4 cycles.
- `ram_wr` high for exactly one cycle per write. Address and data are stable one cycle before and one cycle after.
- `busy` is 1 from T+1 through T+3.

## Configuration
- `RAM_ARB_ROUND_ROBIN_EN` defined: on a tie, grant the requester not served last. The pointer updates only on a grant.
- Not defined: fixed priority, where `req0` always wins a tie. The pointer logic is not built.

## Structure
- Package `ram_arb_pkg` holds:
  - state enum (IDLE, SETUP, STROBE, HOLD)
  - default `ADDR_SIZE` = 10 and `WORD_SIZE` = 8
  - requester-id type (1 bit)
- Sub-module `ram_arb_pick`: combinational winner select from `req0`, `req1` and the last-served id. The macro applies inside it.
- The top level holds the FSM, the request latches, the RAM drive registers and `rdata` capture.

## Test plan
- Reset, then `req0` writes 0xA5 to 0x3FF: `ram_wr` is high only in cycle T+2, with `ram_addr`=0x3FF. `ack0` pulses at T+3. A later read of 0x3FF returns `rdata`=0xA5 with `ack0`.
- `req0` and `req1` held constantly high with round robin enabled: acks alternate 0,1,0,1, each 4 cycles apart, with 0 first after reset. With the macro undefined, only `ack0` ever pulses.
- `req1` only, reading 0x000 after a write of 0x3C: `ack1` is 3 cycles after the grant and `rdata`=0x3C. `ack0` stays 0.
- `req0` rises during STROBE of a `req1` access: it is ignored until IDLE, then granted, and `ack0` comes 4 cycles after `ack1`.
- `rst_n` low during STROBE of a write: the next edge gives IDLE with `ram_wr`=0, `ram_cs`=0, no ack and `busy`=0. A new request is then served normally.
